sm_key_debounce: RTL and testbench
==================================

// Module: sm_key_debounce
// PURPOSE
//  - Conditions raw board keys/switches before they reach the core and board glue
//  - Per channel: 2-FF synchronizer, debounce counter, clean level, 1-cycle press/release pulses
//  - Sits between the board pins (key[5:2], sw[7:0]) and the consumers: single-step clkEnable,
//    reset request, register-address select
// PARAMETERS
//  - WIDTH        4      number of independent input channels
//  - ACTIVE_LOW   1      1: raw pin low = pressed (board keys); 0: raw high = pressed
//  - CNT_W        16     debounce counter width
//  - STABLE_CNT   50000  sampleEn ticks the synchronized input must differ from level before it flips;
//                        legal range 1 .. 2**CNT_W-1
//  - REPEAT_DELAY 500    ticks held before the first auto-repeat (SM_KEY_DEBOUNCE_AUTOREPEAT_EN only)
//  - REPEAT_RATE  100    ticks between later repeats (SM_KEY_DEBOUNCE_AUTOREPEAT_EN only)
// PORTS
//  - clkIn     in   1      single clock for the whole block
//  - rst_n     in   1      reset, synchronous, active-low
//  - sampleEn  in   1      debounce tick (e.g. sm_clk_divider output); tie 1 to count every clock
//  - raw       in   WIDTH  asynchronous pin inputs
//  - level     out  WIDTH  debounced state, 1 = pressed, regardless of ACTIVE_LOW
//  - press     out  WIDTH  1-cycle pulse on a debounced 0->1 transition (and on auto-repeat)
//  - release   out  WIDTH  1-cycle pulse on a debounced 1->0 transition
// BEHAVIOUR
//  - Reset (rst_n=0 at a clkIn edge):
//    - sync FFs load the "not pressed" value
//    - level=0, press=0, release=0, all counters=0
//  - Normalize: s = sync2 ^ ACTIVE_LOW
//  - Per channel, each edge, in priority order:
//    a) s==level: cnt<=0. Applies whether or not sampleEn is high.
//    b) s!=level, sampleEn=1, cnt==STABLE_CNT-1:
//       - level<=s, cnt<=0
//       - press<=s, release<=~s for exactly one cycle
//    c) s!=level, sampleEn=1, otherwise: cnt<=cnt+1
//    d) sampleEn=0: cnt holds
//  - Pulses are registered and deassert on the next edge unless re-triggered.
//  - press and release are never both 1 on the same channel.
//  - Latency from a clean raw edge to the pulse: 2 cycles (sync) + STABLE_CNT ticks.
//    With sampleEn=1 this is STABLE_CNT+2 clkIn edges.
//  - Glitch filtering: any s==level sample restarts the count. Bounces shorter than STABLE_CNT
//    ticks never change level.
//  - No saturation or wrap: cnt never exceeds STABLE_CNT-1.
//  - Channels are fully independent; simultaneous events on several channels are all reported
//    in the same cycle.
//  - Key held through reset release: level starts at 0. A normal press pulse fires once it is
//    debounced. No suppression.
//  - rst_n low mid-count: the count is discarded and no pulse is emitted.
// CONFIGURATION
//  - Macro SM_KEY_DEBOUNCE_AUTOREPEAT_EN defined:
//    - per-channel repeat counter rcnt, cleared whenever level==0
//    - while level==1, rcnt counts sampleEn ticks
//    - extra press pulse at REPEAT_DELAY ticks, then every REPEAT_RATE ticks
//    - release behaviour is unchanged
//  - Macro undefined: rcnt logic is absent; exactly one press per debounced press
// STRUCTURE
//  - Shared constants file sm_key_debounce_pkg: default STABLE_CNT, REPEAT_DELAY, REPEAT_RATE
//    for the 50 MHz board clock
//  - One sub-module sm_debounce_channel (one sync chain, cnt, optional rcnt, pulse regs)
//  - Top instantiates it WIDTH times through a generate loop
// TESTING (WIDTH=4, STABLE_CNT=4, ACTIVE_LOW=1, sampleEn=1 unless stated)
//  - Reset: hold rst_n=0 for 3 clocks with raw=4'b0000 (all pressed)
//    -> level=0, press=0, release=0 while in reset
//    -> after release: press=4'b1111 for 1 cycle at edge 6, then level=4'b1111
//  - Clean press: raw[0] 1->0 and held
//    -> press[0] high for exactly 1 cycle at edge 6 after the change; level[0]=1 afterwards
//    -> release stays 0
//  - Bounce: raw[1] toggles every 2 clocks for 20 clocks, then returns high
//    -> level[1]=0 throughout; press[1] and release[1] never assert
//  - sampleEn gating: sampleEn high one clock in 8, raw[2] pressed
//    -> press[2] fires on the 4th sampleEn tick after sync
//    -> cnt holds between ticks
//  - Simultaneous: raw[3] released while raw[0] pressed in the same clock
//    -> release[3] and press[0] pulse in the same cycle
//  - Auto-repeat, with SM_KEY_DEBOUNCE_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=3, key held
//    -> press pulses at debounce, +10, +13, +16 ticks
//    -> without the macro, exactly one press

Source files
------------

// File: rtl/sm_key_debounce_pkg.sv
// Shared debounce constants for the 50 MHz board clock.
// Repeat timings assume sampleEn comes from a 1 kHz tick divider.
package sm_key_debounce_pkg;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_STABLE_CNT   = 50000;  // 1 ms when sampleEn is tied high
    localparam int DEF_REPEAT_DELAY = 500;
    localparam int DEF_REPEAT_RATE  = 100;

endpackage

// File: rtl/sm_debounce_channel.sv
// One key channel: 2-FF synchronizer, debounce counter, clean level, press/release pulses.
// Optional auto-repeat of press while held: SM_KEY_DEBOUNCE_AUTOREPEAT_EN.
module sm_debounce_channel
    import sm_key_debounce_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic raw,
    output logic level,
    output logic press,
    output logic released
);

    localparam logic             NOT_PRESSED = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] LAST        = CNT_W'(STABLE_CNT - 1);

    if (STABLE_CNT < 1 || STABLE_CNT > 2**CNT_W - 1) begin : g_bad_stable
        $error("STABLE_CNT out of range for CNT_W");
    end
    if (REPEAT_RATE < 1 || REPEAT_DELAY < REPEAT_RATE) begin : g_bad_repeat
        $error("need 1 <= REPEAT_RATE <= REPEAT_DELAY");
    end

    logic             sync1, sync2, s;
    logic [CNT_W-1:0] cnt;
    logic             flip, rpt_hit;

    assign s    = sync2 ^ NOT_PRESSED;
    assign flip = (s != level) && sample_en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= NOT_PRESSED;
            sync2    <= NOT_PRESSED;
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            released <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            press    <= (flip & s) | rpt_hit;
            released <= flip & ~s;
            if (s == level)
                cnt <= '0;
            else if (sample_en) begin
                if (cnt == LAST) begin
                    level <= s;
                    cnt   <= '0;
                end else
                    cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SM_KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] R_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] R_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [CNT_W-1:0] rcnt;

    // A debounced release wins over a repeat landing on the same edge.
    assign rpt_hit = level && sample_en && (rcnt == R_LAST) && !flip;

    // Reloading to DELAY-RATE makes every later hit REPEAT_RATE ticks apart.
    always_ff @(posedge clk) begin
        if (!rst_n || !level)
            rcnt <= '0;
        else if (sample_en)
            rcnt <= (rcnt == R_LAST) ? R_RELOAD : rcnt + 1'b1;
    end
`else
    assign rpt_hit = 1'b0;
`endif

endmodule

// File: rtl/sm_key_debounce.sv
// Debounces WIDTH independent raw keys/switches into level + press/release pulses.
// Auto-repeat of press is enabled by defining SM_KEY_DEBOUNCE_AUTOREPEAT_EN.
module sm_key_debounce
    import sm_key_debounce_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clkIn,
    input  logic             rst_n,
    input  logic             sampleEn,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] released   // "release" is a reserved word
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sm_debounce_channel #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .CNT_W       (CNT_W),
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk      (clkIn),
            .rst_n    (rst_n),
            .sample_en(sampleEn),
            .raw      (raw[i]),
            .level    (level[i]),
            .press    (press[i]),
            .released (released[i])
        );
    end

endmodule

// File: tb/tb_sm_key_debounce.sv
// Scoreboard bench for sm_key_debounce: stimulus queues expected pulses, a monitor pops them.
module tb_sm_key_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [3:0] raw;
    logic [3:0] level, press, released;
    logic       raw2, level2, press2, released2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sm_key_debounce #(
        .WIDTH(4), .ACTIVE_LOW(1), .CNT_W(16), .STABLE_CNT(4),
        .REPEAT_DELAY(60000), .REPEAT_RATE(100)
    ) dut (
        .clkIn(clk), .rst_n(rst_n), .sampleEn(sample_en), .raw(raw),
        .level(level), .press(press), .released(released)
    );

    sm_key_debounce #(
        .WIDTH(1), .ACTIVE_LOW(1), .CNT_W(16), .STABLE_CNT(4),
        .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut_ar (
        .clkIn(clk), .rst_n(rst_n), .sampleEn(1'b1), .raw(raw2),
        .level(level2), .press(press2), .released(released2)
    );

    typedef struct {
        int         cyc;
        logic [3:0] p;
        logic [3:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   obs_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [3:0] p, input logic [3:0] r);
        exp_t e;
        e.cyc = at;
        e.p   = p;
        e.r   = r;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (press != 4'h0 || released != 4'h0) begin
                if (exp_q.size() == 0)
                    chk("unexpected_pulse", {24'h0, press, released}, 32'h0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("press", {28'h0, press}, {28'h0, e.p});
                    chk("release", {28'h0, released}, {28'h0, e.r});
                end
                chk("press_release_excl", {28'h0, press & released}, 32'h0);
            end
            if (press2) obs_q.push_back(cyc);
            if (released2) chk("ar_release", {31'h0, released2}, 32'h0);
        end
    endtask

    initial begin
        int c0, c1;
        int exp2[$];

        rst_n     = 1'b0;
        raw       = 4'h0;
        sample_en = 1'b1;
        raw2      = 1'b1;
        fork
            monitor();
        join_none

        // Keys held pressed through reset
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_level", {28'h0, level}, 32'h0);
            chk("rst_press", {28'h0, press}, 32'h0);
            chk("rst_release", {28'h0, released}, 32'h0);
        end
        rst_n = 1'b1;
        expect_pulse(cyc + 6, 4'hF, 4'h0);
        step(7);
        chk("held_through_reset_level", {28'h0, level}, 32'hF);

        raw = 4'hF;
        expect_pulse(cyc + 6, 4'h0, 4'hF);
        step(8);
        chk("all_released_level", {28'h0, level}, 32'h0);

        // Clean press on channel 0
        raw[0] = 1'b0;
        expect_pulse(cyc + 6, 4'h1, 4'h0);
        step(5);
        chk("pre_debounce_level", {28'h0, level}, 32'h0);
        step(4);
        chk("clean_press_level", {28'h0, level}, 32'h1);

        // Bounce on channel 1: 2-cycle toggles never reach the threshold
        for (int i = 0; i < 10; i++) begin
            raw[1] = ~raw[1];
            step(2);
            chk("bounce_level", {31'h0, level[1]}, 32'h0);
        end
        raw[1] = 1'b1;
        step(8);
        chk("after_bounce_level", {28'h0, level}, 32'h1);

        // Threshold boundary: 3 differing samples ignored, 4 accepted
        raw[1] = 1'b0;
        step(3);
        raw[1] = 1'b1;
        step(8);
        chk("short_glitch_level", {28'h0, level}, 32'h1);
        raw[1] = 1'b0;
        c0 = cyc;
        expect_pulse(c0 + 6, 4'h2, 4'h0);
        expect_pulse(c0 + 10, 4'h0, 4'h2);
        step(4);
        raw[1] = 1'b1;
        step(8);
        chk("exact_glitch_level", {28'h0, level}, 32'h1);

        // Simultaneous events on different channels
        raw[0] = 1'b1;
        raw[3] = 1'b0;
        expect_pulse(cyc + 6, 4'h8, 4'h1);
        step(8);
        chk("swap1_level", {28'h0, level}, 32'h8);
        raw[3] = 1'b1;
        raw[0] = 1'b0;
        expect_pulse(cyc + 6, 4'h1, 4'h8);
        step(8);
        chk("swap2_level", {28'h0, level}, 32'h1);

        // sampleEn one clock in 8: press lands on the 4th tick after sync
        while (cyc % 8 != 0) step(1);
        raw[2] = 1'b0;
        c0 = cyc;
        expect_pulse(c0 + 32, 4'h4, 4'h0);
        for (int i = 0; i < 36; i++) begin
            sample_en = ((cyc + 1) % 8 == 0);
            step(1);
            if (cyc == c0 + 31) chk("gated_pre_level", {31'h0, level[2]}, 32'h0);
        end
        sample_en = 1'b1;
        chk("gated_level", {28'h0, level}, 32'h5);

        // Held key on the repeat-configured instance
        raw2 = 1'b0;
        c1 = cyc;
        step(24);
        exp2.push_back(c1 + 6);
`ifdef SM_KEY_DEBOUNCE_AUTOREPEAT_EN
        exp2.push_back(c1 + 16);
        exp2.push_back(c1 + 19);
        exp2.push_back(c1 + 22);
`endif
        chk("ar_count", obs_q.size(), exp2.size());
        for (int i = 0; i < exp2.size(); i++)
            if (i < obs_q.size()) chk("ar_cycle", obs_q[i], exp2[i]);
        chk("ar_level", {31'h0, level2}, 32'h1);

        step(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
